// File: rtl/multiplo_arbiter_pkg.sv
// Shared definitions for the multiple-test unit arbiter.
//   state_t      : arbiter FSM states
//   REQ_A, REQ_B : requester indices used for grant / last_grant encoding
package multiplo_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_OK,
    RELEASE
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant.
//   req[1:0]    : request from B (bit 1) and A (bit 0)
//   last_grant  : requester served most recently
//   grant_valid : at least one request present
//   grant_idx   : winning requester (REQ_A / REQ_B)
// A tie goes to the requester that was not served last; a single request
// always wins regardless of history.
module rr_arbiter2
  import multiplo_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = REQ_A;
    if (&req) begin
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = REQ_B;
    end
  end

endmodule

// File: rtl/multiplo_arbiter.sv
// Shares one multiple-test unit between requesters A and B.
//   clock, reset               : system clock, synchronous active-high reset
//   x_a/y_a/dav_a_ -> rfd_a    : dav_/rfd input handshake from A
//   m_a, ok_a, err_a           : result, result strobe, timeout flag for A
//   x_b ... err_b              : same for B
//   x_u/y_u/dav_u_ <- rfd_u    : dav_/rfd handshake towards the unit
//   m_u, ok_u                  : unit result and strobe
// All outputs are registered.
module multiplo_arbiter
  import multiplo_arbiter_pkg::*;
#(
  parameter int unsigned X_W         = 4,
  parameter int unsigned Y_W         = 3,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [X_W-1:0] x_a,
  input  logic [Y_W-1:0] y_a,
  input  logic           dav_a_,
  output logic           rfd_a,
  output logic           m_a,
  output logic           ok_a,
  output logic           err_a,
  input  logic [X_W-1:0] x_b,
  input  logic [Y_W-1:0] y_b,
  input  logic           dav_b_,
  output logic           rfd_b,
  output logic           m_b,
  output logic           ok_b,
  output logic           err_b,
  output logic [X_W-1:0] x_u,
  output logic [Y_W-1:0] y_u,
  output logic           dav_u_,
  input  logic           rfd_u,
  input  logic           m_u,
  input  logic           ok_u
);

  // Counter value seen in the last permitted WAIT_OK cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t         state, state_nxt;
  logic           last_grant, last_grant_nxt;
  logic           cur, cur_nxt;
  logic [7:0]     cnt, cnt_nxt;
  logic [X_W-1:0] x_u_nxt;
  logic [Y_W-1:0] y_u_nxt;
  logic           dav_u_nxt, rfd_a_nxt, rfd_b_nxt;
  logic           m_a_nxt, m_b_nxt, ok_a_nxt, ok_b_nxt, err_a_nxt, err_b_nxt;

  logic [1:0]     req;
  logic           grant_valid, grant_idx;
  logic           dav_cur_;
  logic           res;

  assign req      = {~dav_b_ & rfd_u, ~dav_a_ & rfd_u};
  assign dav_cur_ = (cur == REQ_B) ? dav_b_ : dav_a_;

  rr_arbiter2 u_rr (
    .req         (req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cur_nxt        = cur;
    cnt_nxt        = cnt;
    x_u_nxt        = x_u;
    y_u_nxt        = y_u;
    dav_u_nxt      = dav_u_;
    rfd_a_nxt      = rfd_a;
    rfd_b_nxt      = rfd_b;
    m_a_nxt        = m_a;
    m_b_nxt        = m_b;
    ok_a_nxt       = 1'b0;
    ok_b_nxt       = 1'b0;
    err_a_nxt      = 1'b0;
    err_b_nxt      = 1'b0;
    res            = 1'b0;

    case (state)
      IDLE: begin
        if (grant_valid) begin
          cur_nxt   = grant_idx;
          dav_u_nxt = 1'b0;
          state_nxt = ISSUE;
          if (grant_idx == REQ_A) begin
            x_u_nxt   = x_a;
            y_u_nxt   = y_a;
            rfd_a_nxt = 1'b0;
          end else begin
            x_u_nxt   = x_b;
            y_u_nxt   = y_b;
            rfd_b_nxt = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (!rfd_u) begin
          dav_u_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WAIT_OK;
        end
      end
      WAIT_OK: begin
        cnt_nxt = cnt + 8'd1;
        // ok_u has priority over an expiring timeout: err only without ok_u.
        if (ok_u || (cnt == TMO_LAST)) begin
          res       = ok_u & m_u;
          state_nxt = RELEASE;
          if (cur == REQ_A) begin
            m_a_nxt   = res;
            ok_a_nxt  = 1'b1;
            err_a_nxt = ~ok_u;
          end else begin
            m_b_nxt   = res;
            ok_b_nxt  = 1'b1;
            err_b_nxt = ~ok_u;
          end
        end
      end
      RELEASE: begin
        if (dav_cur_ && rfd_u) begin
          if (cur == REQ_A) rfd_a_nxt = 1'b1;
          else              rfd_b_nxt = 1'b1;
          last_grant_nxt = cur;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_B;
      cur        <= REQ_A;
      cnt        <= '0;
      x_u        <= '0;
      y_u        <= '0;
      dav_u_     <= 1'b1;
      rfd_a      <= 1'b1;
      rfd_b      <= 1'b1;
      m_a        <= 1'b0;
      m_b        <= 1'b0;
      ok_a       <= 1'b0;
      ok_b       <= 1'b0;
      err_a      <= 1'b0;
      err_b      <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cur        <= cur_nxt;
      cnt        <= cnt_nxt;
      x_u        <= x_u_nxt;
      y_u        <= y_u_nxt;
      dav_u_     <= dav_u_nxt;
      rfd_a      <= rfd_a_nxt;
      rfd_b      <= rfd_b_nxt;
      m_a        <= m_a_nxt;
      m_b        <= m_b_nxt;
      ok_a       <= ok_a_nxt;
      ok_b       <= ok_b_nxt;
      err_a      <= err_a_nxt;
      err_b      <= err_b_nxt;
    end
  end

endmodule
